// File: rtl/lif_spike_rate_decoder.sv
// Spike-rate decoder: counts spike onsets over a programmable window of
// clock cycles and hands the count out through a valid/ready register, and
// measures the inter-spike interval between consecutive onsets.
module lif_spike_rate_decoder #(
  parameter int CNT_W = 8,
  parameter int WIN_W = 8,
  parameter int ISI_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             spike_in,
  input  logic [WIN_W-1:0] win_len,
  output logic [CNT_W-1:0] rate_out,
  output logic             rate_valid,
  input  logic             rate_ready,
  output logic [ISI_W-1:0] isi_out,
  output logic             isi_valid,
  output logic             overflow
);

  localparam logic [WIN_W-1:0] WIN_ONE = WIN_W'(1);
  localparam logic [ISI_W-1:0] ISI_ONE = ISI_W'(1);

  typedef enum logic {
    IDLE,
    COUNT
  } state_t;

  state_t state;
  state_t state_nxt;

  logic             spike_q;
  logic [WIN_W-1:0] win_q;
  logic [WIN_W-1:0] win_cnt;
  logic [CNT_W-1:0] spk_cnt;
  logic [ISI_W-1:0] isi_cnt;
  logic             isi_armed;

  logic             onset;
  logic [CNT_W-1:0] spk_sum;
  logic             last_cycle;
  logic             start_window;
  logic             load_result;

  // State register; reset forces IDLE regardless of anything else
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state: enter COUNT on a valid window length, leave on en low or a zero re-sampled length
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (en && (win_len != '0)) state_nxt = COUNT;
      COUNT: begin
        if (!en)                                  state_nxt = IDLE;
        else if (last_cycle && (win_len == '0))   state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Decode of onset, saturating running count and window boundary events
  always_comb begin
    onset        = spike_in & ~spike_q;
    spk_sum      = (spk_cnt == '1) ? spk_cnt : spk_cnt + CNT_W'(onset);
    last_cycle   = (state == COUNT) && (win_cnt == win_q - WIN_ONE);
    start_window = (state == IDLE) && en && (win_len != '0);
    load_result  = (state == COUNT) && en && last_cycle;
  end

  // Previous spike level, used to count a multi-cycle spike only once
  always_ff @(posedge clk) begin
    if (rst) spike_q <= 1'b0;
    else     spike_q <= spike_in;
  end

  // Window bookkeeping: restart on entry or at a window boundary, otherwise advance
  always_ff @(posedge clk) begin
    if (rst) begin
      win_q   <= '0;
      win_cnt <= '0;
      spk_cnt <= '0;
    end else if (start_window || load_result) begin
      win_q   <= win_len;
      win_cnt <= '0;
      spk_cnt <= '0;
    end else if ((state == COUNT) && en) begin
      win_cnt <= win_cnt + WIN_ONE;
      spk_cnt <= spk_sum;
    end
  end

  // Result register with valid/ready handshake; an unconsumed result being replaced sets overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      rate_out   <= '0;
      rate_valid <= 1'b0;
      overflow   <= 1'b0;
    end else if (load_result) begin
      rate_out   <= spk_sum;
      rate_valid <= 1'b1;
      if (rate_valid && !rate_ready) overflow <= 1'b1;
    end else if (rate_valid && rate_ready) begin
      rate_valid <= 1'b0;
    end
  end

  // Inter-spike interval: first onset arms, later onsets report the saturating cycle count
  always_ff @(posedge clk) begin
    if (rst) begin
      isi_cnt   <= '0;
      isi_armed <= 1'b0;
      isi_out   <= '0;
      isi_valid <= 1'b0;
    end else if (!en) begin
      isi_cnt   <= '0;
      isi_armed <= 1'b0;
      isi_valid <= 1'b0;
    end else begin
      isi_valid <= 1'b0;
      if (onset) begin
        if (isi_armed) begin
          isi_out   <= isi_cnt;
          isi_valid <= 1'b1;
        end
        isi_armed <= 1'b1;
        isi_cnt   <= ISI_ONE;
      end else if (isi_armed && (isi_cnt != '1)) begin
        isi_cnt <= isi_cnt + ISI_ONE;
      end
    end
  end

endmodule
